// File: rtl/sdram_arbit.sv
// sdram_arbit: grants init/refresh/write/read access to the SDRAM pins, refresh first then write then read.
// Define SDRAM_RW_FAIR_EN to alternate write and read grants when both are requesting.
module sdram_arbit #(
    parameter int          DQ_W    = 16,
    parameter int          ADDR_W  = 13,
    parameter logic [3:0]  NOP_CMD = 4'b0111
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [1:0]        init_ba,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              aref_req,
    input  logic              aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [1:0]        aref_ba,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [1:0]        wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_sdram_en,
    input  logic [DQ_W-1:0]   wr_sdram_data,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [1:0]        rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic [DQ_W-1:0]   sdram_rd_data,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [1:0]        sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    inout  wire  [DQ_W-1:0]   sdram_dq
);
    typedef enum logic [2:0] {IDLE, ARBIT, AREF, WRITE, READ} state_t;
    state_t state, state_nxt;
    logic pick_wr;
    logic [3:0] cmd;
`ifdef SDRAM_RW_FAIR_EN
    logic last_wr;
    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) last_wr <= 1'b0;
        else if (state == ARBIT && state_nxt == WRITE) last_wr <= 1'b1;
        else if (state == ARBIT && state_nxt == READ) last_wr <= 1'b0;
    assign pick_wr = wr_req && !(rd_req && last_wr);
`else
    assign pick_wr = wr_req;
`endif
    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = init_end ? ARBIT : IDLE;
            ARBIT:   state_nxt = aref_req ? AREF : pick_wr ? WRITE : rd_req ? READ : ARBIT;
            AREF:    state_nxt = aref_end ? ARBIT : AREF;
            WRITE:   state_nxt = wr_end ? ARBIT : WRITE;
            READ:    state_nxt = rd_end ? ARBIT : READ;
            default: state_nxt = IDLE;
        endcase
    end
    // enables come from the registered state so they drop the cycle after the end pulse
    assign aref_en = (state == AREF);
    assign wr_en   = (state == WRITE);
    assign rd_en   = (state == READ);
    assign cmd = state == IDLE  ? init_cmd :
                 state == AREF  ? aref_cmd :
                 state == WRITE ? wr_cmd   :
                 state == READ  ? rd_cmd   : NOP_CMD;
    assign sdram_ba = state == IDLE  ? init_ba :
                      state == AREF  ? aref_ba :
                      state == WRITE ? wr_ba   :
                      state == READ  ? rd_ba   : 2'b11;
    assign sdram_addr = state == IDLE  ? init_addr :
                        state == AREF  ? aref_addr :
                        state == WRITE ? wr_addr   :
                        state == READ  ? rd_addr   : {ADDR_W{1'b1}};
    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
    assign sdram_cke = 1'b1;
    assign sdram_dq = (wr_sdram_en && state == WRITE) ? wr_sdram_data : {DQ_W{1'bz}};
    assign sdram_rd_data = sdram_dq;
endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: directed stimulus with a grant scoreboard checked by an independent monitor.
module tb_sdram_arbit;
    logic        sys_clk = 1'b0, sys_rst_n = 1'b0, init_end = 1'b0;
    logic [3:0]  init_cmd = 4'b0010, aref_cmd = 4'b0001, wr_cmd = 4'b0100, rd_cmd = 4'b0101;
    logic [1:0]  init_ba = 2'd0, aref_ba = 2'd0, wr_ba = 2'd1, rd_ba = 2'd2;
    logic [12:0] init_addr = 13'h000, aref_addr = 13'h400, wr_addr = 13'h0AB, rd_addr = 13'h012;
    logic        aref_req = 0, aref_end = 0, wr_req = 0, wr_end = 0, rd_req = 0, rd_end = 0;
    logic        wr_sdram_en = 0, tb_drive = 0;
    logic [15:0] wr_sdram_data = 16'h0, tb_dq = 16'h0;
    logic        aref_en, wr_en, rd_en, sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [15:0] sdram_rd_data;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    wire  [15:0] sdram_dq;
    int checks = 0, failures = 0;

    typedef struct packed {logic [2:0] g; logic [3:0] cmd; logic [1:0] ba; logic [12:0] addr;} exp_t;
    exp_t q[$];

    assign sdram_dq = tb_drive ? tb_dq : 16'bz;
    wire [2:0] grant = {aref_en, wr_en, rd_en};
    wire [3:0] pins = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};

    sdram_arbit dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_end(init_end),
        .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
        .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_ba(aref_ba), .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
        .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_rd_data(sdram_rd_data),
        .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
        .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba),
        .sdram_addr(sdram_addr), .sdram_dq(sdram_dq)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(negedge sys_clk);
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic push(input logic [2:0] g);
        exp_t e;
        e.g = g;
        e.cmd  = g == 3'b100 ? aref_cmd  : g == 3'b010 ? wr_cmd  : rd_cmd;
        e.ba   = g == 3'b100 ? aref_ba   : g == 3'b010 ? wr_ba   : rd_ba;
        e.addr = g == 3'b100 ? aref_addr : g == 3'b010 ? wr_addr : rd_addr;
        q.push_back(e);
    endtask

    task automatic wait_g(input logic [2:0] g);
        int n = 0;
        while (grant !== g && n < 50) begin
            tick();
            n++;
        end
        if (grant !== g) begin
            checks++;
            failures++;
            $display("FAIL grant_timeout: got %b expected %b", grant, g);
        end
    endtask

    task automatic end_pulse(input int idx, input logic [2:0] nxt);
        if (idx == 0) aref_end = 1'b1;
        else if (idx == 1) wr_end = 1'b1;
        else rd_end = 1'b1;
        tick();
        aref_end = 1'b0;
        wr_end = 1'b0;
        rd_end = 1'b0;
        chk("gap_grant", {29'd0, grant}, 32'd0);
        chk("gap_nop", {28'd0, pins}, 32'h7);
        tick();
        chk("next_grant", {29'd0, grant}, {29'd0, nxt});
    endtask

    // monitor: every rising grant must match the next scoreboard entry
    initial begin
        logic [2:0] prev_g;
        prev_g = 3'b000;
        forever begin
            @(negedge sys_clk);
            if (grant != 3'b000 && grant != prev_g) begin
                checks++;
                if (prev_g != 3'b000) begin
                    failures++;
                    $display("FAIL grant_switch: got %b after %b without idle", grant, prev_g);
                end else if (q.size() == 0) begin
                    failures++;
                    $display("FAIL grant_unexpected: got %b expected none", grant);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if ({grant, pins, sdram_ba, sdram_addr} !== e) begin
                        failures++;
                        $display("FAIL grant_order: got g=%b cmd=%b ba=%0d addr=%h expected g=%b cmd=%b ba=%0d addr=%h",
                                 grant, pins, sdram_ba, sdram_addr, e.g, e.cmd, e.ba, e.addr);
                    end
                end
            end
            prev_g = grant;
        end
    end

    initial begin
        logic [2:0] order [4];
`ifdef SDRAM_RW_FAIR_EN
        order = '{3'b010, 3'b001, 3'b010, 3'b001};
`else
        order = '{3'b010, 3'b010, 3'b010, 3'b010};
`endif
        tick();
        chk("rst_pins", {28'd0, pins}, 32'h2);
        chk("rst_cke", {31'd0, sdram_cke}, 32'd1);
        chk("rst_grant", {29'd0, grant}, 32'd0);
        tb_drive = 1'b1;
        tb_dq = 16'h5A3C;
        #1 chk("rst_dq_released", {16'd0, sdram_rd_data}, 32'h5A3C);
        tb_drive = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        repeat (2) tick();
        chk("idle_pins", {28'd0, pins}, 32'h2);
        init_end = 1'b1;
        tick();
        chk("arbit_nop", {28'd0, pins}, 32'h7);
        chk("arbit_ba", {30'd0, sdram_ba}, 32'h3);
        chk("arbit_addr", {19'd0, sdram_addr}, 32'h1FFF);
        init_end = 1'b0;
        tick();
        chk("init_end_drop_ignored", {28'd0, pins}, 32'h7);
        // single read grant
        rd_req = 1'b1;
        push(3'b001);
        wait_g(3'b001);
        rd_req = 1'b0;
        tick();
        chk("rd_pins", {28'd0, pins}, 32'h5);
        chk("rd_addr", {19'd0, sdram_addr}, 32'h012);
        end_pulse(2, 3'b000);
        // all three at once: refresh, then write, then read
        aref_req = 1'b1;
        wr_req = 1'b1;
        rd_req = 1'b1;
        push(3'b100);
        push(3'b010);
        push(3'b001);
        wait_g(3'b100);
        aref_req = 1'b0;
        tick();
        end_pulse(0, 3'b010);
        wr_req = 1'b0;
        tick();
        end_pulse(1, 3'b001);
        rd_req = 1'b0;
        end_pulse(2, 3'b000);
        // refresh raised mid-write waits for wr_end; write data drives dq
        wr_req = 1'b1;
        push(3'b010);
        wait_g(3'b010);
        wr_req = 1'b0;
        aref_req = 1'b1;
        push(3'b100);
        wr_sdram_en = 1'b1;
        wr_sdram_data = 16'hA5A5;
        #1 chk("wr_dq", {16'd0, sdram_dq}, 32'hA5A5);
        repeat (3) tick();
        chk("no_preempt", {29'd0, grant}, 32'h2);
        wr_sdram_en = 1'b0;
        tb_drive = 1'b1;
        tb_dq = 16'h5A3C;
        #1 chk("wr_dq_released", {16'd0, sdram_dq}, 32'h5A3C);
        tb_drive = 1'b0;
        end_pulse(1, 3'b100);
        aref_req = 1'b0;
        end_pulse(0, 3'b000);
        // read data path from an external driver
        rd_req = 1'b1;
        push(3'b001);
        wait_g(3'b001);
        rd_req = 1'b0;
        tb_drive = 1'b1;
        tb_dq = 16'h1234;
        #1 chk("rd_data", {16'd0, sdram_rd_data}, 32'h1234);
        tb_drive = 1'b0;
        end_pulse(2, 3'b000);
        // write and read both held
        wr_req = 1'b1;
        rd_req = 1'b1;
        for (int i = 0; i < 4; i++) push(order[i]);
        for (int i = 0; i < 4; i++) begin
            wait_g(order[i]);
            tick();
            if (i == 3) begin
                wr_req = 1'b0;
                rd_req = 1'b0;
            end
            end_pulse(order[i] == 3'b010 ? 1 : 2, i < 3 ? order[i+1] : 3'b000);
        end
        // reset mid-burst
        wr_req = 1'b1;
        push(3'b010);
        wait_g(3'b010);
        wr_sdram_en = 1'b1;
        wr_sdram_data = 16'hA5A5;
        sys_rst_n = 1'b0;
        #1 chk("rst_mid_grant", {29'd0, grant}, 32'd0);
        chk("rst_mid_pins", {28'd0, pins}, 32'h2);
        tb_drive = 1'b1;
        tb_dq = 16'h5A3C;
        #1 chk("rst_mid_dq_released", {16'd0, sdram_rd_data}, 32'h5A3C);
        tb_drive = 1'b0;
        wr_sdram_en = 1'b0;
        repeat (2) tick();
        sys_rst_n = 1'b1;
        repeat (3) tick();
        chk("wait_init_grant", {29'd0, grant}, 32'd0);
        chk("wait_init_pins", {28'd0, pins}, 32'h2);
        wr_req = 1'b0;
        tick();
        chk("queue_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sdram_arbit.md
Name: sdram_arbit

Overview:
- Command arbiter between the SDRAM sub-controllers (init, auto-refresh, write, read) and the SDRAM pins.
- Grants one requester at a time and drives that requester's enable (aref_en / wr_en / rd_en).
- Muxes the granted {cs_n,ras_n,cas_n,we_n}/ba/addr onto the device pins.
- Owns the bidirectional DQ bus; read data is returned to the read stage on sdram_rd_data.

Parameters:
- DQ_W, 16, SDRAM data width
- ADDR_W, 13, SDRAM address width
- NOP_CMD, 4'b0111, {cs_n,ras_n,cas_n,we_n} NOP encoding

Ports:
- sys_clk  in  1  100 MHz system clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- init_end  in  1  init complete (level)
- init_cmd/init_ba/init_addr  in  4/2/ADDR_W  init-stage command bus
- aref_req  in  1  refresh request (level, held until served)
- aref_end  in  1  refresh done (1-cycle pulse)
- aref_cmd/aref_ba/aref_addr  in  4/2/ADDR_W  refresh command bus
- wr_req  in  1  write request (level)
- wr_end  in  1  write burst done (pulse)
- wr_cmd/wr_ba/wr_addr  in  4/2/ADDR_W  write command bus
- wr_sdram_en  in  1  write stage drives DQ
- wr_sdram_data  in  DQ_W  write data
- rd_req  in  1  read request (level)
- rd_end  in  1  read burst done (pulse)
- rd_cmd/rd_ba/rd_addr  in  4/2/ADDR_W  read command bus
- aref_en  out  1  refresh grant
- wr_en  out  1  write grant
- rd_en  out  1  read grant
- sdram_rd_data  out  DQ_W  DQ input, to read stage rd_data
- sdram_cke  out  1  clock enable
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  command pins
- sdram_ba  out  2  bank
- sdram_addr  out  ADDR_W  address
- sdram_dq  inout  DQ_W  data bus

Behaviour:
- States: IDLE, ARBIT, AREF, WRITE, READ. Reset → IDLE.
- IDLE → ARBIT on init_end=1.
- ARBIT → AREF if aref_req; else WRITE if wr_req; else READ if rd_req; else stay in ARBIT.
- AREF → ARBIT on aref_end. WRITE → ARBIT on wr_end. READ → ARBIT on rd_end.
- Every grant passes through ARBIT, so there is ≥1 idle cycle between bursts.
- aref_en=(state==AREF), wr_en=(state==WRITE), rd_en=(state==READ): decoded from the state register, so each falls in the cycle after the end pulse. This guarantees the sub-controller sees its enable low when it re-enters its idle state and does not relaunch.
- A request raised during another grant is held pending and served at the next ARBIT. There is no pre-emption: a refresh waits for wr_end/rd_end.
- Command mux (combinational from state):
  - IDLE: init_cmd/ba/addr
  - ARBIT: NOP_CMD, ba=2'b11, addr=all-ones
  - AREF / WRITE / READ: the respective stage's bus
- {sdram_cs_n,ras_n,cas_n,we_n} = muxed cmd. sdram_cke=1 always, including during reset.
- sdram_dq = wr_sdram_data when wr_sdram_en=1 and state==WRITE, else high-Z. sdram_rd_data = sdram_dq continuously.
- Reset values:
  - state IDLE; all enables 0; dq high-Z; cke 1
  - cmd/ba/addr follow init_* (the init stage holds NOP in reset)
- Reset mid-burst: immediate return to IDLE, enables drop, dq released. Re-arbitration waits for init_end.
- init_end deasserting after IDLE is ignored.

Optional Feature:
- Macro SDRAM_RW_FAIR_EN.
- Defined:
  - 1-bit last_served register, reset = READ.
  - In ARBIT with wr_req and rd_req both high, grant the one not last served.
  - last_served updates on entry to WRITE or READ.
  - Refresh keeps absolute top priority.
- Undefined: fixed priority aref > write > read; no extra register.

Test Plan:
- Reset, init_cmd=4'b0010, init_end=0 → pins show 4'b0010, cke=1, dq=Z, all enables 0. Set init_end=1 → ARBIT next cycle, pins NOP, ba=3, addr=1FFF.
- rd_req=1 in ARBIT, rd_cmd=4'b0101, rd_addr=0x012 → rd_en=1 next cycle, pins follow rd_*. Pulse rd_end → rd_en=0 the following cycle, pins NOP.
- aref_req, wr_req, rd_req all asserted in the same cycle → AREF granted first. After aref_end: WRITE. After wr_end: READ. One ARBIT cycle between each grant.
- aref_req raised mid-WRITE → wr_en stays 1 until wr_end, then aref_en=1 after one ARBIT cycle.
- WRITE with wr_sdram_en=1, data 0xA5A5 → sdram_dq=0xA5A5. wr_sdram_en=0 → dq=Z. External drive 0x1234 during READ → sdram_rd_data=0x1234.
- With SDRAM_RW_FAIR_EN, wr_req and rd_req held high → grant order WRITE, READ, WRITE, READ. Without the macro → WRITE repeatedly (read starves).
